// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mem_access_unit_pkg
//  Brief   : State codes, access-size codes and shared helpers for the
//            data-memory access stage.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam logic [1:0] C_STATE_IDLE = 2'd0;
  localparam logic [1:0] C_STATE_WAIT = 2'd1;
  localparam logic [1:0] C_STATE_DONE = 2'd2;

  localparam logic [1:0] C_SIZE_WORD = 2'd0;
  localparam logic [1:0] C_SIZE_HALF = 2'd1;
  localparam logic [1:0] C_SIZE_BYTE = 2'd2;

  localparam logic [31:0] C_DEADBEEF = 32'hDEADBEEF;

  typedef logic [1:0] memSize_t;

  // Reserved size code 3 falls into the word case.
  function automatic logic isAligned(input memSize_t size, input logic [1:0] byteOff);
    case (size)
      C_SIZE_HALF: return ~byteOff[0];
      C_SIZE_BYTE: return 1'b1;
      default:     return (byteOff == 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module : mem_access_unit_lane_align
//  Brief  : Combinational byte-lane logic: store byte enables and data
//           replication, load lane select with sign/zero extension.
//  Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  memDataSize,
  input  logic        memBitExtend,
  input  logic [1:0]  byteOff,
  input  logic [31:0] wdata,
  input  logic [31:0] memRdata,
  output logic [3:0]  laneBe,
  output logic [31:0] laneWdata,
  output logic [31:0] loadData
);

  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;

  assign w_loadByte = memRdata[{byteOff, 3'b000} +: 8];
  assign w_loadHalf = byteOff[1] ? memRdata[31:16] : memRdata[15:0];

  always_comb begin
    laneBe    = 4'b1111;
    laneWdata = wdata;
    loadData  = memRdata;
    case (memDataSize)
      C_SIZE_HALF: begin
        laneBe    = byteOff[1] ? 4'b1100 : 4'b0011;
        laneWdata = {2{wdata[15:0]}};
        loadData  = {{16{~memBitExtend & w_loadHalf[15]}}, w_loadHalf};
      end
      C_SIZE_BYTE: begin
        laneBe    = 4'b0001 << byteOff;
        laneWdata = {4{wdata[7:0]}};
        loadData  = {{24{~memBitExtend & w_loadByte[7]}}, w_loadByte};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module : mem_access_unit
//  Brief  : Load/store stage turning decoder requests into a req/ack word bus
//           transaction, stalling the pipeline until completion.
//  Config : MEM_ACCESS_TIMEOUT_EN adds a WAIT-state timeout with bus_error.
//  Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS  = 11,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [1:0]               memDataSize,
  input  logic                     memBitExtend,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     stall,
  output logic                     misaligned,
  output logic                     bus_error,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [3:0]               mem_be,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack
);

  logic [1:0]               r_state;
  logic [1:0]               w_nextState;
  logic                     w_acc;
  logic                     w_aligned;
  logic                     w_start;
  logic                     w_timeout;
  logic [3:0]               w_laneBe;
  logic [31:0]              w_laneWdata;
  logic [31:0]              w_loadData;
  logic [31:0]              r_rdata;
  logic                     r_misaligned;
  logic                     r_memReq;
  logic                     r_memWe;
  logic [MEM_ADDR_BITS-1:0] r_memAddr;
  logic [3:0]               r_memBe;
  logic [31:0]              r_memWdata;
  logic                     w_unusedAddrBits;

  assign w_acc            = memRead | memWrite;
  assign w_aligned        = isAligned(memDataSize, addr[1:0]);
  assign w_start          = w_acc & w_aligned;
  assign w_unusedAddrBits = ^addr[31:MEM_ADDR_BITS+2];

  mem_access_unit_lane_align u_laneAlign (
    .memDataSize  (memDataSize),
    .memBitExtend (memBitExtend),
    .byteOff      (addr[1:0]),
    .wdata        (wdata),
    .memRdata     (mem_rdata),
    .laneBe       (w_laneBe),
    .laneWdata    (w_laneWdata),
    .loadData     (w_loadData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_STATE_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = C_STATE_IDLE;
    case (r_state)
      C_STATE_IDLE: w_nextState = w_start ? C_STATE_WAIT : C_STATE_IDLE;
      C_STATE_WAIT: w_nextState = (mem_ack | w_timeout) ? C_STATE_DONE : C_STATE_WAIT;
      default:      w_nextState = C_STATE_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (r_state)
      C_STATE_IDLE: stall = w_start;
      C_STATE_WAIT: stall = 1'b1;
      default:      stall = 1'b0;
    endcase
  end

  // Bus outputs are registered at launch and held untouched through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= '0;
      r_memBe      <= '0;
      r_memWdata   <= '0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        C_STATE_IDLE: begin
          if (w_start) begin
            r_memReq   <= 1'b1;
            r_memWe    <= memWrite;
            r_memAddr  <= addr[MEM_ADDR_BITS+1:2];
            r_memBe    <= w_laneBe;
            r_memWdata <= w_laneWdata;
          end else if (w_acc) begin
            r_misaligned <= 1'b1;
            r_rdata      <= '0;
          end
        end
        C_STATE_WAIT: begin
          if (mem_ack) begin
            r_memReq <= 1'b0;
            if (!r_memWe) begin
              r_rdata <= w_loadData;
            end
          end else if (w_timeout) begin
            r_memReq <= 1'b0;
            r_rdata  <= C_DEADBEEF;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned C_CNT_BITS = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_BITS-1:0] C_TIMEOUT_LAST = C_CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_BITS-1:0] r_waitCnt;
  logic                  r_busError;

  // Counter holds the number of ack-less WAIT cycles already elapsed.
  assign w_timeout = (r_state == C_STATE_WAIT) && !mem_ack && (r_waitCnt == C_TIMEOUT_LAST);
  assign bus_error = r_busError;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt  <= '0;
      r_busError <= 1'b0;
    end else begin
      r_busError <= w_timeout;
      if (r_state != C_STATE_WAIT) begin
        r_waitCnt <= '0;
      end else if (!mem_ack) begin
        r_waitCnt <= r_waitCnt + C_CNT_BITS'(1);
      end
    end
  end
`else
  logic w_unusedTimeoutParam;

  assign w_timeout            = 1'b0;
  assign bus_error            = 1'b0;
  assign w_unusedTimeoutParam = TIMEOUT_CYCLES[0];
`endif

  assign rdata      = r_rdata;
  assign misaligned = r_misaligned;
  assign mem_req    = r_memReq;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_be     = r_memBe;
  assign mem_wdata  = r_memWdata;

endmodule
`default_nettype wire
